t_spill_buffer: RTL and testbench

T_SPILL_BUFFER -- requirements
Module: t_spill_buffer

---
 rtl/t_spill_buffer.sv | 137 +++++++++++++
 tb/tb_t_spill_buffer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/t_spill_buffer.sv
// Circular spill buffer for packed T/V/F words, gated by an IDLE/RUN/HALT controller.
// Optional macro TSPILL_BYPASS_EN: a simultaneous send+request on an empty FIFO returns the send word directly.
module t_spill_buffer #(
   parameter int WORD_W = 64,
   parameter int ADDR_W = 8,
   parameter int TSZ_W  = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic [TSZ_W-1:0]  i_T_size,
   output logic [TSZ_W-1:0]  o_T_size,
   input  logic              i_sram_send,
   input  logic [WORD_W-1:0] i_send_data,
   input  logic              i_sram_request,
   output logic [WORD_W-1:0] o_request_data,
   output logic              o_request_valid,
   output logic              o_full,
   output logic              o_empty,
   output logic [ADDR_W:0]   o_count,
   output logic              o_ready,
   output logic              o_overflow,
   output logic              o_underflow
);

   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

   state_t state, state_next;
   logic [WORD_W-1:0] mem [0:(1<<ADDR_W)-1];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [ADDR_W:0]   count;
   logic do_write, do_read, do_bypass, set_overflow, set_underflow;

   assign o_count = count;
   assign o_full  = (count == DEPTH);
   assign o_empty = (count == '0);
   assign o_ready = (state == RUN);

   // Decide what this cycle's strobes do; any protocol error parks the buffer in HALT.
   always_comb begin
      state_next    = state;
      do_write      = 1'b0;
      do_read       = 1'b0;
      do_bypass     = 1'b0;
      set_overflow  = 1'b0;
      set_underflow = 1'b0;
      if (i_start) begin
         state_next = RUN;
      end else if (state == RUN) begin
         if (i_sram_send && i_sram_request) begin
            if (o_empty) begin
`ifdef TSPILL_BYPASS_EN
               do_bypass = 1'b1;
`else
               do_write      = 1'b1;
               set_underflow = 1'b1;
               state_next    = HALT;
`endif
            end else begin
               do_write = 1'b1;
               do_read  = 1'b1;
            end
         end else if (i_sram_send) begin
            if (!o_full) begin
               do_write = 1'b1;
            end else begin
               set_overflow = 1'b1;
               state_next   = HALT;
            end
         end else if (i_sram_request) begin
            if (!o_empty) begin
               do_read = 1'b1;
            end else begin
               set_underflow = 1'b1;
               state_next    = HALT;
            end
         end
      end
   end

   // Storage array is deliberately left uninitialised on reset.
   always_ff @(posedge clk) begin
      if (do_write && !rst) begin
         mem[wr_ptr] <= i_send_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         count           <= '0;
         o_T_size        <= '0;
         o_request_data  <= '0;
         o_request_valid <= 1'b0;
         o_overflow      <= 1'b0;
         o_underflow     <= 1'b0;
      end else if (i_start) begin
         state           <= RUN;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         count           <= '0;
         o_T_size        <= i_T_size;
         o_request_valid <= 1'b0;
         o_overflow      <= 1'b0;
         o_underflow     <= 1'b0;
      end else begin
         state           <= state_next;
         o_request_valid <= do_read | do_bypass;
         // A full-FIFO read and write share an address; the read sees the old word.
         if (do_read) begin
            o_request_data <= mem[rd_ptr];
            rd_ptr         <= rd_ptr + 1'b1;
         end else if (do_bypass) begin
            o_request_data <= i_send_data;
         end
         if (do_write) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_write && !do_read) begin
            count <= count + 1'b1;
         end else if (do_read && !do_write) begin
            count <= count - 1'b1;
         end
         if (set_overflow) begin
            o_overflow <= 1'b1;
         end
         if (set_underflow) begin
            o_underflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_t_spill_buffer.sv
// Self-checking bench for t_spill_buffer: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_t_spill_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_start = 1'b0;
   logic [11:0] i_T_size = '0;
   logic [11:0] o_T_size;
   logic        i_sram_send = 1'b0;
   logic [63:0] i_send_data = '0;
   logic        i_sram_request = 1'b0;
   logic [63:0] o_request_data;
   logic        o_request_valid;
   logic        o_full, o_empty;
   logic [8:0]  o_count;
   logic        o_ready, o_overflow, o_underflow;

   t_spill_buffer dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_T_size(i_T_size), .o_T_size(o_T_size),
      .i_sram_send(i_sram_send), .i_send_data(i_send_data), .i_sram_request(i_sram_request),
      .o_request_data(o_request_data), .o_request_valid(o_request_valid),
      .o_full(o_full), .o_empty(o_empty), .o_count(o_count), .o_ready(o_ready),
      .o_overflow(o_overflow), .o_underflow(o_underflow)
   );

   always #5 clk = ~clk;

   int total_checks = 0;
   int bad_checks = 0;

   // Reference model state
   logic [63:0] q[$];
   bit          m_running = 0;
   logic [11:0] m_tsize = '0;
   logic [63:0] m_data = '0;
   bit          m_valid = 0;
   bit          m_ovf = 0;
   bit          m_unf = 0;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total_checks++;
      if (observed !== expected) begin
         bad_checks++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic updateModel();
      if (rst) begin
         m_running = 0; q.delete(); m_tsize = '0; m_data = '0;
         m_valid = 0; m_ovf = 0; m_unf = 0;
      end else if (i_start) begin
         m_running = 1; q.delete(); m_tsize = i_T_size;
         m_valid = 0; m_ovf = 0; m_unf = 0;
      end else if (m_running) begin
         m_valid = 0;
         if (i_sram_send && i_sram_request && q.size() == 0) begin
`ifdef TSPILL_BYPASS_EN
            m_valid = 1; m_data = i_send_data;
`else
            q.push_back(i_send_data); m_unf = 1; m_running = 0;
`endif
         end else if (i_sram_send && i_sram_request) begin
            m_data = q.pop_front(); m_valid = 1; q.push_back(i_send_data);
         end else if (i_sram_send) begin
            if (q.size() < 256) q.push_back(i_send_data);
            else begin m_ovf = 1; m_running = 0; end
         end else if (i_sram_request) begin
            if (q.size() > 0) begin m_data = q.pop_front(); m_valid = 1; end
            else begin m_unf = 1; m_running = 0; end
         end
      end else begin
         m_valid = 0;
      end
   endtask

   task automatic checkAll();
      checkOutput("valid", 64'(o_request_valid), 64'(m_valid));
      checkOutput("data", o_request_data, m_data);
      checkOutput("count", 64'(o_count), 64'(q.size()));
      checkOutput("full", 64'(o_full), 64'(q.size() == 256));
      checkOutput("empty", 64'(o_empty), 64'(q.size() == 0));
      checkOutput("ready", 64'(o_ready), 64'(m_running));
      checkOutput("overflow", 64'(o_overflow), 64'(m_ovf));
      checkOutput("underflow", 64'(o_underflow), 64'(m_unf));
      checkOutput("tsize", 64'(o_T_size), 64'(m_tsize));
   endtask

   task automatic applyStimulus(input bit rst_v, input bit start_v, input logic [11:0] tsz,
                                input bit send_v, input logic [63:0] data_v, input bit req_v);
      rst = rst_v; i_start = start_v; i_T_size = tsz;
      i_sram_send = send_v; i_send_data = data_v; i_sram_request = req_v;
      @(posedge clk);
      updateModel();
      #1;
      checkAll();
   endtask

   initial begin
      int len, p_send, p_req;
      // Reset state
      applyStimulus(1, 0, 12'd0, 0, 64'd0, 0);
      applyStimulus(1, 1, 12'd55, 1, 64'h77, 1);

      // Basic three-word transfer
      applyStimulus(0, 1, 12'd300, 0, 64'd0, 0);
      applyStimulus(0, 0, 12'd0, 1, 64'hA1, 0);
      applyStimulus(0, 0, 12'd0, 1, 64'hA2, 0);
      applyStimulus(0, 0, 12'd0, 1, 64'hA3, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 12'd0, 0, 64'd0, 1);
      applyStimulus(0, 0, 12'd0, 0, 64'd0, 0);
      checkOutput("tsize300", 64'(o_T_size), 64'd300);

      // Fill to full, overflow, then strobes ignored in HALT
      applyStimulus(0, 1, 12'd7, 0, 64'd0, 0);
      for (int i = 0; i < 256; i++) applyStimulus(0, 0, 12'd0, 1, 64'(1000 + i), 0);
      applyStimulus(0, 0, 12'd0, 1, 64'hDEAD, 0);
      checkOutput("ovf_flag", 64'(o_overflow), 64'd1);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 12'd0, 1, 64'hBAD, 1);

      // Full FIFO send+request, then drain across the pointer wrap
      applyStimulus(0, 1, 12'd9, 0, 64'd0, 0);
      for (int i = 0; i < 256; i++) applyStimulus(0, 0, 12'd0, 1, 64'(2000 + i), 0);
      applyStimulus(0, 0, 12'd0, 1, 64'hBB, 1);
      checkOutput("full_swap_data", o_request_data, 64'd2000);
      for (int i = 0; i < 256; i++) applyStimulus(0, 0, 12'd0, 0, 64'd0, 1);
      checkOutput("last_is_bb", o_request_data, 64'hBB);

      // Empty FIFO send+request
      applyStimulus(0, 1, 12'd1, 0, 64'd0, 0);
      applyStimulus(0, 0, 12'd0, 1, 64'h5C, 1);
      applyStimulus(0, 0, 12'd0, 0, 64'd0, 0);

      // Reset right after a request discards the pending read
      applyStimulus(0, 1, 12'd2, 0, 64'd0, 0);
      applyStimulus(0, 0, 12'd0, 1, 64'h11, 0);
      applyStimulus(0, 0, 12'd0, 0, 64'd0, 1);
      applyStimulus(1, 0, 12'd0, 0, 64'd0, 1);
      checkOutput("rst_valid", 64'(o_request_valid), 64'd0);
      applyStimulus(0, 1, 12'd3, 0, 64'd0, 0);
      checkOutput("restart_ready", 64'(o_ready), 64'd1);

      // Randomized episodes
      for (int e = 0; e < 14; e++) begin
         applyStimulus(0, 1, 12'($urandom_range(0, 4095)), 0, 64'd0, 0);
         len = $urandom_range(30, 160);
         p_send = $urandom_range(10, 90);
         p_req = $urandom_range(10, 90);
         for (int c = 0; c < len; c++) begin
            applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 149) == 0,
                          12'($urandom_range(0, 4095)),
                          $urandom_range(0, 99) < p_send, {$urandom, $urandom},
                          $urandom_range(0, 99) < p_req);
         end
      end

      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule
